// File: rtl/ttl_74f_bcd_counter.sv
// ttl_74f_bcd_counter: cascaded modulo-N up/down digit counter with load, ENP/ENT enables and ripple carry
module ttl_74f_bcd_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LOAD,
    input  logic [WIDTH*DIGITS-1:0]   D,
    input  logic                      ENP,
    input  logic                      ENT,
    input  logic                      UP,
    output logic [WIDTH*DIGITS-1:0]   Q,
    output logic                      RCO
);
    localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    logic [WIDTH*DIGITS-1:0] q_q, q_d, cnt;
    logic [WIDTH-1:0] dig;
    logic run, term, ovr;
    always_comb begin
        cnt  = q_q;
        run  = ENT;
        dig  = '0;
        term = 1'b0;
        ovr  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            dig  = q_q[k*WIDTH +: WIDTH];
            ovr  = {1'b0, dig} >= MOD;
            term = UP ? (dig == TOP) : (dig == '0);
            if (ENP && run)
                cnt[k*WIDTH +: WIDTH] = UP ? ((term || ovr) ? '0 : dig + 1'b1)
                                           : ((dig == '0 || ovr) ? TOP : dig - 1'b1);
            run = run & term;
        end
        q_d = LOAD ? D : cnt;
        RCO = run;
    end
    always_ff @(posedge CLK) begin
        if (RST)
            q_q <= '0;
        else
            q_q <= q_d;
    end
    assign Q = q_q;
endmodule

// File: tb/tb_ttl_74f_bcd_counter.sv
// tb_ttl_74f_bcd_counter: table-driven scoreboard bench for the BCD (10x2) and hex (16x3) configurations
module tb_ttl_74f_bcd_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, load_a = 1'b0, enp_a = 1'b0, ent_a = 1'b0, up_a = 1'b1;
    logic [7:0]  d_a = '0, q_a;
    logic        rco_a;
    logic        rst_b = 1'b1, load_b = 1'b0, enp_b = 1'b0, ent_b = 1'b0, up_b = 1'b1;
    logic [11:0] d_b = '0, q_b;
    logic        rco_b;

    ttl_74f_bcd_counter dut_a (
        .CLK(clk), .RST(rst_a), .LOAD(load_a), .D(d_a), .ENP(enp_a), .ENT(ent_a),
        .UP(up_a), .Q(q_a), .RCO(rco_a)
    );

    ttl_74f_bcd_counter #(.WIDTH(4), .MODULUS(16), .DIGITS(3)) dut_b (
        .CLK(clk), .RST(rst_b), .LOAD(load_b), .D(d_b), .ENP(enp_b), .ENT(ent_b),
        .UP(up_b), .Q(q_b), .RCO(rco_b)
    );

    typedef struct {
        bit          sel;
        logic        rst, load, enp, ent, up;
        logic [11:0] d;
        logic [11:0] q;
        logic        rco;
        string       name;
    } vec_t;

    typedef struct {
        bit          sel;
        logic [11:0] q;
        logic        rco;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tv[26];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [11:0] bcd(input int n);
        return {4'h0, 4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        check(e.name, e.sel ? q_b : {4'h0, q_a}, e.q);
        check({e.name, "_rco"}, {11'h0, e.sel ? rco_b : rco_a}, {11'h0, e.rco});
    endtask

    task automatic drive(input vec_t v);
        if (!v.sel) begin
            rst_a = v.rst; load_a = v.load; enp_a = v.enp; ent_a = v.ent; up_a = v.up; d_a = v.d[7:0];
        end else begin
            rst_b = v.rst; load_b = v.load; enp_b = v.enp; ent_b = v.ent; up_b = v.up; d_b = v.d;
        end
        sb.push_back('{v.sel, v.q, v.rco, v.name});
        @(posedge clk);
        #1;
        sample();
    endtask

    initial begin
        //          sel rst ld enp ent up  d       q       rco name
        tv[0]  = '{0, 1, 0, 1, 1, 1, 12'h000, 12'h000, 0, "reset"};
        tv[1]  = '{0, 0, 1, 1, 1, 1, 12'h047, 12'h047, 0, "load_over_count"};
        tv[2]  = '{0, 0, 1, 1, 1, 1, 12'h00C, 12'h00C, 0, "load_illegal_up"};
        tv[3]  = '{0, 0, 0, 1, 1, 1, 12'h000, 12'h000, 0, "recover_up"};
        tv[4]  = '{0, 0, 1, 1, 1, 0, 12'h00C, 12'h00C, 0, "load_illegal_dn"};
        tv[5]  = '{0, 0, 0, 1, 1, 0, 12'h000, 12'h009, 0, "recover_dn"};
        tv[6]  = '{0, 0, 1, 1, 1, 1, 12'h099, 12'h099, 1, "load_99"};
        tv[7]  = '{0, 0, 0, 0, 1, 1, 12'h000, 12'h099, 1, "hold_enp0"};
        tv[8]  = '{0, 0, 0, 1, 0, 1, 12'h000, 12'h099, 0, "hold_ent0"};
        tv[9]  = '{0, 1, 1, 1, 1, 1, 12'h047, 12'h000, 0, "rst_over_load"};
        tv[10] = '{0, 0, 1, 1, 1, 1, 12'h099, 12'h099, 1, "load_99b"};
        tv[11] = '{0, 0, 0, 1, 1, 1, 12'h000, 12'h000, 0, "wrap_up"};
        tv[12] = '{0, 0, 0, 1, 1, 0, 12'h000, 12'h099, 0, "wrap_dn"};
        tv[13] = '{0, 0, 1, 0, 0, 0, 12'h040, 12'h040, 0, "load_40"};
        tv[14] = '{0, 0, 0, 1, 1, 0, 12'h000, 12'h039, 0, "borrow"};
        tv[15] = '{0, 0, 0, 0, 1, 0, 12'h000, 12'h039, 0, "hold_dn"};
        tv[16] = '{0, 0, 1, 0, 1, 0, 12'h000, 12'h000, 1, "load_00_dn"};
        tv[17] = '{0, 0, 1, 0, 1, 1, 12'h0C9, 12'h0C9, 0, "load_C9"};
        tv[18] = '{0, 0, 0, 1, 1, 1, 12'h000, 12'h000, 0, "hi_recover"};
        tv[19] = '{1, 1, 0, 0, 0, 1, 12'h000, 12'h000, 0, "b_reset"};
        tv[20] = '{1, 0, 1, 1, 1, 1, 12'hFFE, 12'hFFE, 0, "b_load_ffe"};
        tv[21] = '{1, 0, 0, 1, 1, 1, 12'h000, 12'hFFF, 1, "b_fff"};
        tv[22] = '{1, 0, 0, 1, 1, 1, 12'h000, 12'h000, 0, "b_wrap"};
        tv[23] = '{1, 0, 0, 1, 1, 1, 12'h000, 12'h001, 0, "b_step"};
        tv[24] = '{1, 1, 1, 1, 1, 1, 12'h123, 12'h000, 0, "b_rst_over_load"};
        tv[25] = '{1, 0, 0, 1, 1, 0, 12'h000, 12'hFFF, 0, "b_wrap_dn"};

        #1;
        drive('{0, 1, 0, 1, 1, 1, 12'h000, 12'h000, 0, "rst_up"});
        up_a = 1'b0;
        #1;
        check("rco_comb_down", {11'h0, rco_a}, 12'h001);

        for (int i = 0; i < 26; i++) drive(tv[i]);

        drive('{0, 1, 0, 1, 1, 1, 12'h000, 12'h000, 0, "sweep_reset"});
        for (int n = 1; n <= 100; n++)
            drive('{0, 0, 0, 1, 1, 1, 12'h000, bcd(n % 100), (n % 100) == 99, "sweep_up"});

        drive('{0, 0, 1, 1, 1, 1, 12'h047, 12'h047, 0, "load_47"});
        for (int i = 1; i <= 48; i++)
            drive('{0, 0, 0, 1, 1, 0, 12'h000, bcd((147 - i) % 100), ((147 - i) % 100) == 0, "sweep_dn"});

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
